imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader sitting directly upstream of the single-cycle MIPS core's instruction memory.
- Accepts the program as a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words.
- Writes each word into instruction memory at consecutive byte addresses (0, 4, 8, ...).
- Holds the CPU until loading completes, replacing the bench-side file preload with a synthesizable path.

Parameters:
- MAX_WORDS, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  program byte, most significant byte of each word first.
- in_last  in  1  qualifies the final byte of the program; meaningful only while in_valid.
- in_ready  out  1  loader can accept a byte.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  32  byte address of the word being written.
- im_wdata  out  32  word being written.
- cpu_hold  out  1  keeps the core's PC at 0 and gates its register-file/data-memory writes.
- done  out  1  load complete, level.
- word_count  out  $clog2(MAX_WORDS)+1  words written in the current or last load.
- err  out  2  sticky flags: [0] overflow, [1] misaligned last byte.

Behaviour:
- Reset (asynchronous) values: state=IDLE, in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_hold=1, done=0, word_count=0, err=0.
- State IDLE:
  - in_ready=0.
  - start -> LOAD; clears byte index, word_count and err; sets cpu_hold=1.
- State LOAD:
  - in_ready=1 except in the WRITE cycle.
  - Byte accepted when in_valid & in_ready.
  - Byte k of the word (k=0..3) goes to bits [31-8k -: 8].
  - Acceptance of byte 3, or acceptance of in_last at any k -> WRITE.
  - start is ignored in LOAD.
- State WRITE (exactly one cycle):
  - im_we=1, im_addr=BASE_ADDR+4*word_count, im_wdata=packed word, in_ready=0.
  - word_count increments at the end of the cycle.
  - If the word was ended by in_last -> DONE, else -> LOAD.
- Latency: im_we asserts on the cycle immediately after the handshake of the 4th byte (or of the last byte).
- Throughput: at most 4 bytes per 5 cycles.
- Misaligned last: in_last on byte k<3 zero-fills the remaining low bytes, writes the word, and sets err[1].
- Overflow:
  - A byte accepted while word_count==MAX_WORDS is discarded (no write) and sets err[0].
  - in_ready stays 1 so the stream drains.
  - in_last on a discarded byte -> DONE.
- State DONE:
  - done=1, cpu_hold=0, in_ready=0.
  - start -> LOAD (reasserts cpu_hold and clears done on the next edge).
- Simultaneous in_valid and start in IDLE/DONE: the byte is not accepted (in_ready=0); the transition to LOAD occurs.
- Empty program: start followed by the first accepted byte carrying in_last -> one zero-padded word; err[1] set unless it was a full 4-byte word.
- Reset mid-load:
  - The partial word is discarded, no write is issued, and state=IDLE with cpu_hold=1.
  - Already-written memory words are not cleared.
- Address arithmetic is 32-bit and wraps modulo 2^32; MAX_WORDS bounds it in practice.

Decomposition:
- Package mips_loader_pkg holds the state encoding (IDLE, LOAD, WRITE, DONE), the WORD_BYTES=4 constant and the err bit indices.
- Sub-module word_packer holds the byte index counter, shift/insert of bytes, zero-fill and the word_complete flag.
- The FSM, address counter and flags stay in imem_loader.

Test Plan:
- Stream 8 bytes 20 08 00 05 | 21 09 00 03 (in_last on the 8th), in_valid held high:
  - im_we pulses twice: addr 0x0 data 0x20080005, then addr 0x4 data 0x21090003.
  - done=1, cpu_hold=0, word_count=2, err=0.
- Random in_valid gaps (e.g. 1-3 idle cycles between bytes) on the same stream -> identical writes and data, no byte lost or duplicated.
- 6 bytes AA BB CC DD 11 22 with in_last on 0x22:
  - Writes 0xAABBCCDD at 0x0, then 0x11220000 at 0x4.
  - err=2'b10, word_count=2.
- MAX_WORDS=2 with 12 bytes:
  - Exactly two writes, at 0x0 and 0x4.
  - err[0]=1, done=1 after the 12th byte, word_count=2.
- Assert rst after 5 bytes:
  - Only the word at 0x0 is written; all outputs return to reset values within the same cycle.
  - A subsequent start plus a 4-byte stream writes at addr 0x0 again.
- After DONE, pulse start and send 4 bytes:
  - cpu_hold rises the next cycle; a new write lands at 0x0; done re-asserts.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared encodings for the instruction-memory loader: FSM states, word size, err bit positions.
// No logic; imported by word_packer and imem_loader.
package mips_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WORD_BYTES   = 4;
  localparam int ERR_OVF      = 0;
  localparam int ERR_MISALIGN = 1;

endpackage

// File: rtl/word_packer.sv
// Packs bytes big-endian into a 32-bit word; zero-fills a word cut short by last.
// Latency: word is valid the cycle after the completing push; no backpressure of its own.
module word_packer
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_dat,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_complete,
  output logic        misaligned
);

  logic [1:0] idx;
  logic       at_end;

  assign at_end        = (idx == 2'(WORD_BYTES - 1));
  assign word_complete = push & (at_end | last);
  assign misaligned    = push & last & ~at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= 2'd0;
      word <= 32'h0;
    end else if (clr) begin
      idx  <= 2'd0;
      word <= 32'h0;
    end else if (push) begin
      // Byte 0 reloads the whole word, so any bytes never written stay zero.
      case (idx)
        2'd0:    word          <= {byte_dat, 24'h0};
        2'd1:    word[23:16]   <= byte_dat;
        2'd2:    word[15:8]    <= byte_dat;
        default: word[7:0]     <= byte_dat;
      endcase
      idx <= word_complete ? 2'd0 : idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wide program into instruction memory and holds the CPU until the load is done.
// Latency: im_we one cycle after the completing byte; in_ready drops for that write cycle (4 bytes / 5 cycles).
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         im_we,
  output logic [31:0]                  im_addr,
  output logic [31:0]                  im_wdata,
  output logic                         cpu_hold,
  output logic                         done,
  output logic [$clog2(MAX_WORDS):0]   word_count,
  output logic [1:0]                   err
);

  localparam int CW = $clog2(MAX_WORDS) + 1;

  state_t state, state_nxt;
  logic   ended_last;
  logic   accept, full, push, drop, clr;
  logic   word_complete, misaligned;

  assign accept = in_valid & in_ready;
  assign full   = (word_count == CW'(MAX_WORDS));
  assign push   = accept & ~full;
  assign drop   = accept & full;
  assign clr    = start & ((state == ST_IDLE) | (state == ST_DONE));

  assign im_addr = BASE_ADDR + (32'(word_count) << 2);

  word_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .push          (push),
    .byte_dat      (in_data),
    .last          (in_last),
    .word          (im_wdata),
    .word_complete (word_complete),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    im_we     = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        // Overflowed bytes keep draining; a dropped last byte still ends the load.
        if (word_complete)        state_nxt = ST_WRITE;
        else if (drop && in_last) state_nxt = ST_DONE;
      end
      ST_WRITE: begin
        im_we     = 1'b1;
        state_nxt = ended_last ? ST_DONE : ST_LOAD;
      end
      default: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_count <= '0;
      err        <= 2'b00;
      ended_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        word_count <= '0;
        err        <= 2'b00;
      end else begin
        if (state == ST_WRITE) word_count <= word_count + CW'(1);
        if (drop)              err[ERR_OVF]      <= 1'b1;
        if (misaligned)        err[ERR_MISALIGN] <= 1'b1;
      end
      if (word_complete) ended_last <= in_last;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance plus a MAX_WORDS=2 instance for overflow.
// The idle instance has its start/in_valid gated off so only the selected one sees traffic.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        sel = 1'b0;

  logic        start_m, vld_m, start_s, vld_s;
  logic        in_ready, im_we, cpu_hold, done;
  logic [31:0] im_addr, im_wdata;
  logic [8:0]  word_count;
  logic [1:0]  err;
  logic        s_in_ready, s_im_we, s_cpu_hold, s_done;
  logic [31:0] s_im_addr, s_im_wdata;
  logic [1:0]  s_word_count;
  logic [1:0]  s_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] ma[$], md[$], sa[$], sd[$];

  assign start_m = start & ~sel;
  assign vld_m   = in_valid & ~sel;
  assign start_s = start & sel;
  assign vld_s   = in_valid & sel;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start_m), .in_valid(vld_m), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_hold(cpu_hold), .done(done), .word_count(word_count), .err(err)
  );

  imem_loader #(.MAX_WORDS(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(vld_s), .in_data(in_data),
    .in_last(in_last), .in_ready(s_in_ready), .im_we(s_im_we), .im_addr(s_im_addr),
    .im_wdata(s_im_wdata), .cpu_hold(s_cpu_hold), .done(s_done), .word_count(s_word_count),
    .err(s_err)
  );

  always @(negedge clk) begin
    if (im_we === 1'b1) begin ma.push_back(im_addr); md.push_back(im_wdata); end
    if (s_im_we === 1'b1) begin sa.push_back(s_im_addr); sd.push_back(s_im_wdata); end
  end

  task automatic clear_q();
    ma.delete(); md.delete(); sa.delete(); sd.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    forever begin
      @(negedge clk);
      if ((sel ? s_in_ready : in_ready) === 1'b1) break;
      n++;
      if (n > 50) begin
        $display("FAIL send_timeout: in_ready never rose for byte %h", d);
        errors++; checks++;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((sel ? s_done : done) === 1'b1) break;
    end
    checks++;
    if (n >= 50) begin
      $display("FAIL done_timeout: done not seen within 50 cycles");
      errors++;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b0)    begin $display("FAIL rst_in_ready: got %b want 0", in_ready); errors++; end
    checks++; if (im_we !== 1'b0)       begin $display("FAIL rst_im_we: got %b want 0", im_we); errors++; end
    checks++; if (im_addr !== 32'h0)    begin $display("FAIL rst_im_addr: got %h want 0", im_addr); errors++; end
    checks++; if (im_wdata !== 32'h0)   begin $display("FAIL rst_im_wdata: got %h want 0", im_wdata); errors++; end
    checks++; if (cpu_hold !== 1'b1)    begin $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); errors++; end
    checks++; if (done !== 1'b0)        begin $display("FAIL rst_done: got %b want 0", done); errors++; end
    checks++; if (word_count !== 9'd0)  begin $display("FAIL rst_word_count: got %0d want 0", word_count); errors++; end
    checks++; if (err !== 2'b00)        begin $display("FAIL rst_err: got %b want 00", err); errors++; end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    checks++; if (in_ready !== 1'b0)    begin $display("FAIL idle_in_ready: got %b want 0", in_ready); errors++; end
  endtask

  task automatic test_basic();
    logic [31:0] ea[2], ed[2];
    ea = '{32'h0, 32'h4}; ed = '{32'h20080005, 32'h21090003};
    sel = 1'b0; clear_q();
    do_start();
    send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    checks++; if (im_we !== 1'b1)        begin $display("FAIL basic_latency_we: got %b want 1", im_we); errors++; end
    checks++; if (im_wdata !== 32'h20080005) begin $display("FAIL basic_latency_data: got %h want 20080005", im_wdata); errors++; end
    send_byte(8'h21, 0); send_byte(8'h09, 0); send_byte(8'h00, 0); send_byte(8'h03, 1);
    wait_done();
    checks++; if (ma.size() != 2) begin $display("FAIL basic_nwrites: got %0d want 2", ma.size()); errors++; end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= ma.size() || ma[i] !== ea[i] || md[i] !== ed[i]) begin
        $display("FAIL basic_write%0d: want addr %h data %h", i, ea[i], ed[i]); errors++;
      end
    end
    checks++; if (done !== 1'b1)       begin $display("FAIL basic_done: got %b want 1", done); errors++; end
    checks++; if (cpu_hold !== 1'b0)   begin $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); errors++; end
    checks++; if (word_count !== 9'd2) begin $display("FAIL basic_word_count: got %0d want 2", word_count); errors++; end
    checks++; if (err !== 2'b00)       begin $display("FAIL basic_err: got %b want 00", err); errors++; end
  endtask

  task automatic test_gaps();
    logic [7:0]  b[8];
    int          g[8];
    logic [31:0] ed[2];
    b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h03};
    g = '{1, 3, 2, 1, 2, 3, 1, 0};
    ed = '{32'h20080005, 32'h21090003};
    sel = 1'b0; clear_q();
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(b[i], i == 7);
      if (g[i] > 0) idle(g[i]);
    end
    wait_done();
    checks++; if (ma.size() != 2) begin $display("FAIL gaps_nwrites: got %0d want 2", ma.size()); errors++; end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= ma.size() || ma[i] !== 32'(4 * i) || md[i] !== ed[i]) begin
        $display("FAIL gaps_write%0d: want addr %h data %h", i, 4 * i, ed[i]); errors++;
      end
    end
    checks++; if (word_count !== 9'd2) begin $display("FAIL gaps_word_count: got %0d want 2", word_count); errors++; end
  endtask

  task automatic test_misaligned();
    sel = 1'b0; clear_q();
    do_start();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 1);
    wait_done();
    checks++;
    if (ma.size() != 2 || md[0] !== 32'hAABBCCDD || md[1] !== 32'h11220000 || ma[1] !== 32'h4) begin
      $display("FAIL mis_writes: n=%0d want AABBCCDD@0 11220000@4", ma.size()); errors++;
    end
    checks++; if (err !== 2'b10)       begin $display("FAIL mis_err: got %b want 10", err); errors++; end
    checks++; if (word_count !== 9'd2) begin $display("FAIL mis_word_count: got %0d want 2", word_count); errors++; end
  endtask

  task automatic test_overflow();
    sel = 1'b1; clear_q();
    do_start();
    for (int i = 1; i <= 12; i++) send_byte(8'(i), i == 12);
    wait_done();
    checks++;
    if (sa.size() != 2 || sa[0] !== 32'h0 || sa[1] !== 32'h4 ||
        sd[0] !== 32'h01020304 || sd[1] !== 32'h05060708) begin
      $display("FAIL ovf_writes: n=%0d want 01020304@0 05060708@4", sa.size()); errors++;
    end
    checks++; if (s_err !== 2'b01)       begin $display("FAIL ovf_err: got %b want 01", s_err); errors++; end
    checks++; if (s_done !== 1'b1)       begin $display("FAIL ovf_done: got %b want 1", s_done); errors++; end
    checks++; if (s_word_count !== 2'd2) begin $display("FAIL ovf_word_count: got %0d want 2", s_word_count); errors++; end
    sel = 1'b0;
  endtask

  task automatic test_reset_midload();
    sel = 1'b0; clear_q();
    do_start();
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 0);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== 32'h0 || im_wdata !== 32'h0 ||
        cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 9'd0 || err !== 2'b00) begin
      $display("FAIL midrst_outputs: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b wc=%0d err=%b",
               in_ready, im_we, im_addr, im_wdata, cpu_hold, done, word_count, err);
      errors++;
    end
    checks++;
    if (ma.size() != 1 || ma[0] !== 32'h0 || md[0] !== 32'h10111213) begin
      $display("FAIL midrst_writes: n=%0d want one 10111213@0", ma.size()); errors++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    do_start();
    send_byte(8'h30, 0); send_byte(8'h31, 0); send_byte(8'h32, 0); send_byte(8'h33, 1);
    wait_done();
    checks++;
    if (ma.size() != 2 || ma[1] !== 32'h0 || md[1] !== 32'h30313233) begin
      $display("FAIL midrst_reload: n=%0d want 30313233@0", ma.size()); errors++;
    end
  endtask

  task automatic test_restart();
    sel = 1'b0; clear_q();
    checks++; if (done !== 1'b1) begin $display("FAIL restart_pre_done: got %b want 1", done); errors++; end
    start = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (cpu_hold !== 1'b1) begin $display("FAIL restart_hold: got %b want 1", cpu_hold); errors++; end
    checks++; if (done !== 1'b0)     begin $display("FAIL restart_done_clr: got %b want 0", done); errors++; end
    send_byte(8'hC0, 0); send_byte(8'hDE, 0); send_byte(8'hCA, 0); send_byte(8'hFE, 1);
    checks++;
    if (im_we !== 1'b1 || im_addr !== 32'h0 || im_wdata !== 32'hC0DECAFE) begin
      $display("FAIL restart_write: we=%b addr=%h data=%h want 1 0 C0DECAFE", im_we, im_addr, im_wdata);
      errors++;
    end
    wait_done();
    checks++; if (ma.size() != 1)      begin $display("FAIL restart_nwrites: got %0d want 1", ma.size()); errors++; end
    checks++; if (done !== 1'b1)       begin $display("FAIL restart_done: got %b want 1", done); errors++; end
    checks++; if (word_count !== 9'd1) begin $display("FAIL restart_word_count: got %0d want 1", word_count); errors++; end
    checks++; if (err !== 2'b00)       begin $display("FAIL restart_err: got %b want 00", err); errors++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_misaligned();
    test_overflow();
    test_reset_midload();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
